// File: rtl/diff_commit_buf.sv
// diff_commit_buf: diff-test commit trace buffer at the retire point.
// Each retiring instruction produces one normalised record: x0 write-backs
// are cleared, and non-store store fields are zeroed. Records go into a
// first-word-fall-through FIFO that the harness drains with valid/ready.
// The block also keeps accept/drop counters, a sticky overflow flag and a
// registered almost-full stall request.
module diff_commit_buf #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int RADDR_W      = 5,
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       commit_valid_i,
    input  logic [ADDR_W-1:0]          commit_pc_i,
    input  logic [RADDR_W-1:0]         commit_rd_addr_i,
    input  logic                       commit_wreg_i,
    input  logic [DATA_W-1:0]          commit_wdata_i,
    input  logic                       commit_store_i,
    input  logic [ADDR_W-1:0]          commit_store_addr_i,
    input  logic [DATA_W-1:0]          commit_store_wdata_i,
    input  logic [1:0]                 commit_store_wlen_i,
    input  logic                       trace_ready_i,
    output logic                       trace_valid_o,
    output logic [ADDR_W-1:0]          trace_pc_o,
    output logic [RADDR_W-1:0]         trace_rd_addr_o,
    output logic                       trace_wreg_o,
    output logic [DATA_W-1:0]          trace_wdata_o,
    output logic                       trace_store_o,
    output logic [ADDR_W-1:0]          trace_store_addr_o,
    output logic [DATA_W-1:0]          trace_store_wdata_o,
    output logic [1:0]                 trace_store_wlen_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       stall_o,
    output logic                       overflow_o,
    output logic [63:0]                commit_cnt_o,
    output logic [31:0]                drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] L_DEPTH  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] L_MARGIN = CNT_W'(STALL_MARGIN);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [RADDR_W-1:0] rd_addr;
        logic               wreg;
        logic [DATA_W-1:0]  wdata;
        logic               store;
        logic [ADDR_W-1:0]  store_addr;
        logic [DATA_W-1:0]  store_wdata;
        logic [1:0]         store_wlen;
    } rec_t;

    rec_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_stall;
    logic             r_overflow;
    logic [63:0]      r_commit_cnt;
    logic [31:0]      r_drop_cnt;

    rec_t             w_rec;
    rec_t             w_head;
    logic             w_valid;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_free_nxt;

    // Build the normalised record from the retire-stage inputs.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves a field
        // unassigned, which would otherwise infer a latch.
        w_rec         = '0;
        w_rec.pc      = commit_pc_i;
        w_rec.rd_addr = commit_rd_addr_i;
        w_rec.store   = commit_store_i;
        if (commit_rd_addr_i != '0) begin
            w_rec.wreg  = commit_wreg_i;
            w_rec.wdata = commit_wdata_i;
        end
        if (commit_store_i) begin
            w_rec.store_addr  = commit_store_addr_i;
            w_rec.store_wdata = commit_store_wdata_i;
            w_rec.store_wlen  = commit_store_wlen_i;
        end
    end

    // Handshake decode and next occupancy.
    always_comb begin
        w_valid     = (r_count != '0);
        w_full      = (r_count == L_DEPTH);
        w_pop       = w_valid && trace_ready_i;
        w_push      = commit_valid_i && (!w_full || w_pop);
        w_drop      = commit_valid_i && !w_push;
        w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_free_nxt  = L_DEPTH - w_count_nxt;
    end

    // Record storage: written at the write pointer on every accepted push.
    // NOTE: the array has no reset; stale entries are never observable
    // because the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            // NOTE: non-blocking assignment so every register in the design
            // updates from pre-edge values.
            r_mem[r_wptr] <= w_rec;
        end
    end

    // Pointers, occupancy, stall, overflow and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_stall      <= 1'b0;
            r_overflow   <= 1'b0;
            r_commit_cnt <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_stall <= (w_free_nxt <= L_MARGIN);
            if (w_push) begin
                r_wptr       <= r_wptr + PTR_W'(1);
                r_commit_cnt <= r_commit_cnt + 64'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + 32'd1;
                end
            end
        end
    end

    // First-word-fall-through head view, zeroed while empty.
    always_comb begin
        w_head              = w_valid ? r_mem[r_rptr] : '0;
        trace_valid_o       = w_valid;
        trace_pc_o          = w_head.pc;
        trace_rd_addr_o     = w_head.rd_addr;
        trace_wreg_o        = w_head.wreg;
        trace_wdata_o       = w_head.wdata;
        trace_store_o       = w_head.store;
        trace_store_addr_o  = w_head.store_addr;
        trace_store_wdata_o = w_head.store_wdata;
        trace_store_wlen_o  = w_head.store_wlen;
    end

    assign count_o      = r_count;
    assign stall_o      = r_stall;
    assign overflow_o   = r_overflow;
    assign commit_cnt_o = r_commit_cnt;
    assign drop_cnt_o   = r_drop_cnt;

endmodule

// File: tb/tb_diff_commit_buf.sv
// Directed testbench for diff_commit_buf with default parameters
// (DEPTH=8, STALL_MARGIN=2). Inputs change 1 ns after each rising edge,
// and outputs are sampled at that same point.
module tb_diff_commit_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid_i;
    logic [63:0] commit_pc_i;
    logic [4:0]  commit_rd_addr_i;
    logic        commit_wreg_i;
    logic [63:0] commit_wdata_i;
    logic        commit_store_i;
    logic [63:0] commit_store_addr_i;
    logic [63:0] commit_store_wdata_i;
    logic [1:0]  commit_store_wlen_i;
    logic        trace_ready_i;
    logic        trace_valid_o;
    logic [63:0] trace_pc_o;
    logic [4:0]  trace_rd_addr_o;
    logic        trace_wreg_o;
    logic [63:0] trace_wdata_o;
    logic        trace_store_o;
    logic [63:0] trace_store_addr_o;
    logic [63:0] trace_store_wdata_o;
    logic [1:0]  trace_store_wlen_o;
    logic [3:0]  count_o;
    logic        stall_o;
    logic        overflow_o;
    logic [63:0] commit_cnt_o;
    logic [31:0] drop_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    diff_commit_buf dut (
        .clk                  (clk),
        .rst                  (rst),
        .commit_valid_i       (commit_valid_i),
        .commit_pc_i          (commit_pc_i),
        .commit_rd_addr_i     (commit_rd_addr_i),
        .commit_wreg_i        (commit_wreg_i),
        .commit_wdata_i       (commit_wdata_i),
        .commit_store_i       (commit_store_i),
        .commit_store_addr_i  (commit_store_addr_i),
        .commit_store_wdata_i (commit_store_wdata_i),
        .commit_store_wlen_i  (commit_store_wlen_i),
        .trace_ready_i        (trace_ready_i),
        .trace_valid_o        (trace_valid_o),
        .trace_pc_o           (trace_pc_o),
        .trace_rd_addr_o      (trace_rd_addr_o),
        .trace_wreg_o         (trace_wreg_o),
        .trace_wdata_o        (trace_wdata_o),
        .trace_store_o        (trace_store_o),
        .trace_store_addr_o   (trace_store_addr_o),
        .trace_store_wdata_o  (trace_store_wdata_o),
        .trace_store_wlen_o   (trace_store_wlen_o),
        .count_o              (count_o),
        .stall_o              (stall_o),
        .overflow_o           (overflow_o),
        .commit_cnt_o         (commit_cnt_o),
        .drop_cnt_o           (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input logic [63:0] pc, input logic [4:0] rd, input logic wreg,
                           input logic [63:0] wdata, input logic store,
                           input logic [63:0] saddr, input logic [63:0] sdata,
                           input logic [1:0] wlen);
        commit_valid_i       = 1'b1;
        commit_pc_i          = pc;
        commit_rd_addr_i     = rd;
        commit_wreg_i        = wreg;
        commit_wdata_i       = wdata;
        commit_store_i       = store;
        commit_store_addr_i  = saddr;
        commit_store_wdata_i = sdata;
        commit_store_wlen_i  = wlen;
    endtask

    task automatic idle();
        commit_valid_i = 1'b0;
    endtask

    task automatic push_pc(input logic [63:0] pc);
        set_rec(pc, 5'd5, 1'b1, pc, 1'b0, '0, '0, 2'd0);
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        trace_ready_i = 1'b0;
        set_rec('0, '0, 1'b0, '0, 1'b0, '0, '0, 2'd0);
        idle();
        tick();
        tick();
        rst = 1'b0;
        check("rst_count", count_o, 0);
        check("rst_valid", trace_valid_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_ccnt", commit_cnt_o, 0);
        check("rst_dcnt", drop_cnt_o, 0);
        check("rst_pc", trace_pc_o, 0);

        // Three commits with the harness stalled; head is the first PC.
        set_rec(64'h8000_0000, 5'd5, 1'b1, 64'h11, 1'b0, '0, '0, 2'd0);
        tick();
        check("lat_valid", trace_valid_o, 1);
        check("lat_pc", trace_pc_o, 64'h8000_0000);
        set_rec(64'h8000_0004, 5'd5, 1'b1, 64'h22, 1'b0, '0, '0, 2'd0);
        tick();
        set_rec(64'h8000_0008, 5'd5, 1'b1, 64'h33, 1'b0, '0, '0, 2'd0);
        tick();
        idle();
        check("fill3_count", count_o, 3);
        check("fill3_pc", trace_pc_o, 64'h8000_0000);
        check("fill3_wdata", trace_wdata_o, 64'h11);
        check("fill3_rd", trace_rd_addr_o, 5);
        trace_ready_i = 1'b1;
        tick();
        check("drain_pc1", trace_pc_o, 64'h8000_0004);
        check("drain_wd1", trace_wdata_o, 64'h22);
        check("drain_cnt1", count_o, 2);
        tick();
        check("drain_pc2", trace_pc_o, 64'h8000_0008);
        check("drain_wd2", trace_wdata_o, 64'h33);
        tick();
        check("drain_valid", trace_valid_o, 0);
        check("drain_ccnt", commit_cnt_o, 3);
        trace_ready_i = 1'b0;

        // x0 suppression and store normalisation, then a real store record.
        set_rec(64'h40, 5'd0, 1'b1, 64'hDEAD, 1'b0, 64'h1234, 64'h55, 2'd3);
        tick();
        set_rec(64'h100, 5'd7, 1'b1, 64'hBEEF, 1'b1, 64'h2000, 64'hCAFE, 2'd2);
        tick();
        idle();
        check("x0_wreg", trace_wreg_o, 0);
        check("x0_wdata", trace_wdata_o, 0);
        check("nst_addr", trace_store_addr_o, 0);
        check("nst_sdata", trace_store_wdata_o, 0);
        check("nst_wlen", trace_store_wlen_o, 0);
        trace_ready_i = 1'b1;
        tick();
        trace_ready_i = 1'b0;
        check("st_wreg", trace_wreg_o, 1);
        check("st_wdata", trace_wdata_o, 64'hBEEF);
        check("st_store", trace_store_o, 1);
        check("st_addr", trace_store_addr_o, 64'h2000);
        check("st_sdata", trace_store_wdata_o, 64'hCAFE);
        check("st_wlen", trace_store_wlen_o, 2);
        trace_ready_i = 1'b1;
        tick();
        trace_ready_i = 1'b0;
        check("st_empty", trace_valid_o, 0);

        // Ten commits into an eight-entry FIFO with no drain.
        for (int i = 0; i < 10; i++) begin
            push_pc(64'h1000 + 64'(4 * i));
            if (i == 4) check("stall_at5", stall_o, 0);
            if (i == 5) check("stall_at6", stall_o, 1);
            if (i == 7) check("ovf_at8", overflow_o, 0);
        end
        check("full_count", count_o, 8);
        check("full_dcnt", drop_cnt_o, 2);
        check("full_ovf", overflow_o, 1);
        check("full_pc", trace_pc_o, 64'h1000);
        check("full_ccnt", commit_cnt_o, 13);

        // Full, ready and commit together: nothing is dropped.
        trace_ready_i = 1'b1;
        push_pc(64'h9000);
        check("fpp_count", count_o, 8);
        check("fpp_dcnt", drop_cnt_o, 2);
        check("fpp_ccnt", commit_cnt_o, 14);
        for (int i = 1; i < 8; i++) begin
            check("fpp_order", trace_pc_o, 64'h1000 + 64'(4 * i));
            tick();
        end
        check("fpp_new_pc", trace_pc_o, 64'h9000);
        check("fpp_cnt1", count_o, 1);
        check("fpp_stall", stall_o, 0);
        tick();
        check("fpp_empty", trace_valid_o, 0);

        // Twenty streaming push/pop cycles: occupancy stays at one.
        for (int k = 0; k < 20; k++) begin
            set_rec(64'h2000 + 64'(4 * k), 5'd3, 1'b1, 64'(k), 1'b0, '0, '0, 2'd0);
            tick();
            check("strm_pc", trace_pc_o, 64'h2000 + 64'(4 * k));
            check("strm_count", count_o, 1);
        end
        idle();
        check("strm_ccnt", commit_cnt_o, 34);
        tick();
        check("strm_empty", trace_valid_o, 0);
        trace_ready_i = 1'b0;

        // Reset mid-operation with five stored records and overflow set.
        for (int i = 0; i < 5; i++) push_pc(64'h3000 + 64'(4 * i));
        check("pre_rst_count", count_o, 5);
        check("pre_rst_ovf", overflow_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", count_o, 0);
        check("mid_rst_valid", trace_valid_o, 0);
        check("mid_rst_ovf", overflow_o, 0);
        check("mid_rst_ccnt", commit_cnt_o, 0);
        check("mid_rst_dcnt", drop_cnt_o, 0);
        check("mid_rst_pc", trace_pc_o, 0);
        tick();
        check("post_rst_valid", trace_valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
